router_sync_n: RTL and testbench
================================

Name: router_sync_n

Overview:
- Parametrised synchroniser/steering block between the router FSM, the register block and NUM_CH output FIFOs.
- Latches the destination address of each packet and steers the FSM write strobe to one FIFO.
- Multiplexes that FIFO's full flag back to the FSM and drives per-channel valid outputs.
- Runs a per-channel read-timeout that soft-resets a FIFO nobody drains.
- Additions over the 3-channel generation: any channel count, a programmable timeout, invalid-address detection, and an address lock while a packet is being written.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16).
- ADDR_W, 2, width of data_in address field; must satisfy 2**ADDR_W >= NUM_CH.
- TIMEOUT, 31, number of consecutive undrained cycles before soft reset (1..1023). Counter width CNT_W = clog2(TIMEOUT+1).

Ports:
- clock  in  1  clock, rising edge
- resetn  in  1  synchronous, active-low reset
- detect_add  in  1  FSM: address byte present on data_in
- data_in  in  ADDR_W  destination address field
- write_enb_reg  in  1  FSM: write current byte to selected FIFO
- read_enb  in  NUM_CH  per-channel read enable from destination
- empty  in  NUM_CH  per-channel FIFO empty
- full  in  NUM_CH  per-channel FIFO full
- write_enb  out  NUM_CH  one-hot FIFO write strobe
- fifo_full  out  1  full flag of selected channel
- vld_out  out  NUM_CH  per-channel data valid
- soft_reset  out  NUM_CH  per-channel soft reset pulse
- addr_err  out  1  latched address is not a valid channel

Behaviour:
- Reset: when resetn=0 at a rising edge, add_reg=0, addr_err=0, all counters=0. Outputs follow from this: write_enb=0 (write_enb_reg permitting), soft_reset=0, fifo_full=full[0], vld_out=~empty.
- Address latch: on a rising edge with detect_add=1 and write_enb_reg=0, add_reg<=data_in and addr_err<=(data_in>=NUM_CH).
  - detect_add=1 together with write_enb_reg=1 is ignored; add_reg and addr_err hold (address lock).
  - Otherwise both hold.
  - addr_err stays set until the next accepted detect_add.
- write_enb (combinational):
  - bit[add_reg]=1 when write_enb_reg=1 and addr_err=0.
  - All zero otherwise.
  - Channel 0 is bit 0; this replaces the old reversed bit order.
- fifo_full (combinational): full[add_reg] when addr_err=0, else 0. Same cycle as full; no latency.
- vld_out[i] = ~empty[i], combinational.
- Timeout counter, one per channel i, CNT_W bits. Each rising edge:
  - empty[i]=1 or read_enb[i]=1: cnt<=0.
  - Else, cnt==TIMEOUT: cnt<=0 (wrap).
  - Else: cnt<=cnt+1.
- soft_reset[i] = (cnt_i==TIMEOUT).
  - Combinational from the register; a one-cycle pulse.
  - First asserted TIMEOUT edges after the first undrained cycle.
  - If the channel is still undrained afterwards, it repeats every TIMEOUT+1 cycles.
- Simultaneous events:
  - read_enb[i] rising in the same cycle soft_reset[i] is high still clears cnt; the pulse is not extended.
  - Channels are fully independent; several soft_resets may assert in the same cycle.
- Reset mid-timeout clears all counters immediately; no pulse is emitted.

Optional Feature:
- Macro ROUTER_SYNC_TIMEOUT_STS_EN.
- When defined:
  - Adds input timeout_clr (NUM_CH) and output timeout_sts (NUM_CH).
  - timeout_sts[i] is set on any edge where soft_reset[i]=1.
  - It is cleared on an edge where timeout_clr[i]=1 and soft_reset[i]=0; set wins.
  - Reset value 0.
- When undefined: neither port exists and there is no extra state.

Test Plan:
1. Reset: resetn=0 for 2 clocks with all empty=1 -> write_enb=0, soft_reset=0, addr_err=0, vld_out=3'b000.
2. Steering: detect_add with data_in=2, then write_enb_reg=1, full=3'b100 -> write_enb=3'b100, fifo_full=1 in the same cycle.
3. Invalid address: detect_add with data_in=3 (NUM_CH=3), then write_enb_reg=1 -> write_enb=0, fifo_full=0, addr_err=1. Next detect_add with data_in=1 -> addr_err=0.
4. Address lock: write_enb_reg=1 with add_reg=0, pulse detect_add with data_in=1 -> add_reg stays 0 and write_enb stays 3'b001.
5. Timeout: empty[1]=0, read_enb[1]=0 held -> soft_reset[1] high exactly on the 31st cycle, again 32 cycles later. read_enb[1]=1 at cycle 20 -> counter clears and no pulse occurs.
6. With ROUTER_SYNC_TIMEOUT_STS_EN: after the test-5 pulse, timeout_sts[1]=1. timeout_clr[1]=1 -> 0 next edge. timeout_clr coincident with a pulse -> remains 1.

Source files
------------

// File: rtl/router_sync_n.sv
// ----------------------------------------------------------------------------
// router_sync_n
//
// Steering/synchroniser between the router FSM, the register block and
// NUM_CH output FIFOs. Latches each packet's destination address, steers the
// FSM write strobe to the selected FIFO, returns that FIFO's full flag, and
// drives per-channel valid outputs. Each channel also runs a read-timeout
// counter: a FIFO that holds data nobody drains for TIMEOUT cycles gets a
// one-cycle soft_reset pulse. The pulse repeats every TIMEOUT+1 cycles while
// the FIFO stays undrained.
//
// Parameters:
//   NUM_CH  - number of output channels (2..16)
//   ADDR_W  - width of the address field, 2**ADDR_W >= NUM_CH
//   TIMEOUT - undrained cycles before soft reset (1..1023)
//
// Ports:
//   clock          in   rising-edge clock
//   resetn         in   synchronous, active-low reset
//   detect_add     in   address byte present on data_in
//   data_in        in   destination address field
//   write_enb_reg  in   write current byte to the selected FIFO
//   read_enb       in   per-channel read enable from the destinations
//   empty          in   per-channel FIFO empty
//   full           in   per-channel FIFO full
//   write_enb      out  one-hot FIFO write strobe, bit i = channel i
//   fifo_full      out  full flag of the selected channel
//   vld_out        out  per-channel data valid (~empty)
//   soft_reset     out  per-channel soft reset pulse
//   addr_err       out  latched address is not a valid channel
//
// Optional feature (macro ROUTER_SYNC_TIMEOUT_STS_EN):
//   timeout_clr    in   per-channel clear of the sticky timeout status
//   timeout_sts    out  per-channel sticky status, set by soft_reset
// ----------------------------------------------------------------------------
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 31
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
    ,
    input  logic [NUM_CH-1:0] timeout_clr,
    output logic [NUM_CH-1:0] timeout_sts
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);
    // One extra bit so NUM_CH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   NUM_CH_CMP = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] add_reg;
    logic [CNT_W-1:0]  cnt [NUM_CH];

    // Handshake: the FSM presents an address with detect_add for one cycle and
    // then streams bytes with write_enb_reg. An address presented while a byte
    // is being written (write_enb_reg=1) is dropped so a packet in flight
    // cannot be re-steered mid-stream.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            add_reg  <= '0;
            addr_err <= 1'b0;
        end else if (detect_add && !write_enb_reg) begin
            add_reg  <= data_in;
            addr_err <= ({1'b0, data_in} >= NUM_CH_CMP);
        end
    end

    // Steering and full-flag return. An invalid address selects nothing, so
    // the FSM sees not-full and its writes are silently discarded.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(add_reg) == i) begin
                write_enb[i] = write_enb_reg && !addr_err;
                fifo_full    = full[i] && !addr_err;
            end
        end
    end

    assign vld_out = ~empty;

    // Per-channel read timeout. The counter wraps to 0 right after reaching
    // TIMEOUT, which yields a one-cycle pulse and a TIMEOUT+1 repeat period.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_timeout
        always_ff @(posedge clock) begin
            if (!resetn) begin
                cnt[g] <= '0;
            end else if (empty[g] || read_enb[g]) begin
                cnt[g] <= '0;
            end else if (cnt[g] == CNT_MAX) begin
                cnt[g] <= '0;
            end else begin
                cnt[g] <= cnt[g] + 1'b1;
            end
        end
    end

    always_comb begin
        soft_reset = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            soft_reset[i] = (cnt[i] == CNT_MAX);
        end
    end

`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
    // Sticky status: a pulse on the same edge as a clear wins over the clear.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            timeout_sts <= '0;
        end else begin
            timeout_sts <= (timeout_sts & ~timeout_clr) | soft_reset;
        end
    end
`endif

endmodule

// File: tb/tb_router_sync_n.sv
// ----------------------------------------------------------------------------
// tb_router_sync_n
//
// Directed bench for router_sync_n (NUM_CH=3, ADDR_W=2, TIMEOUT=31). Inputs
// change 1 time unit after a rising edge; outputs are sampled 1 time unit
// after that, well away from the active edge. Expected values are
// hand-computed constants.
// ----------------------------------------------------------------------------
module tb_router_sync_n;

    localparam int NUM_CH  = 3;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 31;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              resetn;
    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_enb_reg;
    logic [NUM_CH-1:0] read_enb;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] write_enb;
    logic              fifo_full;
    logic [NUM_CH-1:0] vld_out;
    logic [NUM_CH-1:0] soft_reset;
    logic              addr_err;
`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
    logic [NUM_CH-1:0] timeout_clr;
    logic [NUM_CH-1:0] timeout_sts;
`endif

    router_sync_n #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .detect_add   (detect_add),
        .data_in      (data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb     (read_enb),
        .empty        (empty),
        .full         (full),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .vld_out      (vld_out),
        .soft_reset   (soft_reset),
        .addr_err     (addr_err)
`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
        ,
        .timeout_clr  (timeout_clr),
        .timeout_sts  (timeout_sts)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int pulses;
    int gap;

    // ---------------- directed sequence ----------------
    initial begin
        resetn        = 1'b0;
        detect_add    = 1'b0;
        data_in       = '0;
        write_enb_reg = 1'b0;
        read_enb      = '0;
        empty         = '1;
        full          = '0;
`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
        timeout_clr   = '0;
`endif

        // 1. Reset
        ticks(2);
        #1;
        check("rst_write_enb", write_enb, 3'b000);
        check("rst_soft_reset", soft_reset, 3'b000);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_vld_out", vld_out, 3'b000);
        full = 3'b001;
        #1;
        check("rst_fifo_full_ch0", fifo_full, 1'b1);
        full = 3'b000;
`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
        check("rst_timeout_sts", timeout_sts, 3'b000);
`endif
        resetn = 1'b1;
        tick();

        // 2. Steering to channel 2
        detect_add = 1'b1;
        data_in    = 2'd2;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b100;
        #1;
        check("steer_write_enb", write_enb, 3'b100);
        check("steer_fifo_full", fifo_full, 1'b1);
        full = 3'b011;
        #1;
        check("steer_fifo_full_other", fifo_full, 1'b0);
        empty = 3'b010;
        #1;
        check("vld_out_pattern", vld_out, 3'b101);
        empty = 3'b111;
        write_enb_reg = 1'b0;
        #1;
        check("steer_idle_write_enb", write_enb, 3'b000);

        // 3. Invalid address
        detect_add = 1'b1;
        data_in    = 2'd3;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b111;
        #1;
        check("inv_addr_err", addr_err, 1'b1);
        check("inv_write_enb", write_enb, 3'b000);
        check("inv_fifo_full", fifo_full, 1'b0);
        ticks(3);
        check("inv_addr_err_sticky", addr_err, 1'b1);
        write_enb_reg = 1'b0;
        detect_add    = 1'b1;
        data_in       = 2'd1;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        full          = 3'b010;
        #1;
        check("valid_addr_err_clear", addr_err, 1'b0);
        check("valid_write_enb_ch1", write_enb, 3'b010);
        check("valid_fifo_full_ch1", fifo_full, 1'b1);

        // 4. Address lock
        write_enb_reg = 1'b0;
        full          = 3'b000;
        detect_add    = 1'b1;
        data_in       = 2'd0;
        tick();
        detect_add    = 1'b0;
        write_enb_reg = 1'b1;
        #1;
        check("lock_pre_write_enb", write_enb, 3'b001);
        detect_add = 1'b1;
        data_in    = 2'd1;
        tick();
        detect_add = 1'b0;
        #1;
        check("lock_hold_write_enb", write_enb, 3'b001);
        detect_add = 1'b1;
        data_in    = 2'd3;
        tick();
        detect_add = 1'b0;
        #1;
        check("lock_hold_addr_err", addr_err, 1'b0);
        check("lock_hold_write_enb2", write_enb, 3'b001);
        write_enb_reg = 1'b0;

        // 5. Timeout on channel 1: first pulse on the 31st undrained edge
        empty = 3'b101;
        ticks(30);
        check("to_no_pulse_at_30", soft_reset, 3'b000);
        tick();
        check("to_pulse_at_31", soft_reset, 3'b010);
        tick();
        check("to_pulse_one_cycle", soft_reset, 3'b000);
`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
        // 6a. status set by the pulse, cleared by timeout_clr
        check("sts_set", timeout_sts, 3'b010);
        timeout_clr = 3'b010;
        tick();
        timeout_clr = 3'b000;
        check("sts_cleared", timeout_sts, 3'b000);
`else
        tick();
`endif
        // Two edges past the pulse; the next pulse is 32 edges after it.
        ticks(29);
        check("to_no_repeat_early", soft_reset, 3'b000);
        tick();
        check("to_repeat_at_32", soft_reset, 3'b010);
`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
        // 6b. clear coincident with a pulse: set wins
        timeout_clr = 3'b010;
        tick();
        timeout_clr = 3'b000;
        check("sts_set_wins", timeout_sts, 3'b010);
`else
        tick();
`endif
        check("to_repeat_one_cycle", soft_reset, 3'b000);

        // Read at cycle 20 clears the counter: no pulse 31 edges after start
        ticks(18);
        read_enb = 3'b010;
        tick();
        read_enb = 3'b000;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (soft_reset[1]) pulses++;
        end
        check("read_clear_no_pulse", pulses, 0);
        tick();
        check("read_clear_restart", soft_reset, 3'b010);

        // read_enb while the pulse is high: cleared, not extended
        read_enb = 3'b010;
        tick();
        read_enb = 3'b000;
        check("read_during_pulse", soft_reset, 3'b000);
        gap = 0;
        while (!soft_reset[1] && gap < 40) begin
            tick();
            gap++;
        end
        check("read_during_pulse_gap", gap, 31);

        // Reset mid-timeout clears counters; then all channels time out together
        ticks(10);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mid_reset_no_pulse", soft_reset, 3'b000);
        empty = 3'b000;
        ticks(30);
        check("all_ch_no_pulse_30", soft_reset, 3'b000);
        tick();
        check("all_ch_pulse_31", soft_reset, 3'b111);
        empty = 3'b111;
        tick();
        check("all_ch_idle", soft_reset, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
